// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one tagged memory request port between icache and dcache.
// Tracks write-data beats, routes response beats by tag MSB, and limits outstanding reads.
module mem_rr_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int TAG_BITS  = 5,
    parameter int RD_BEATS  = 4,
    parameter int WR_BEATS  = 4,
    parameter int MAX_OUT   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ic_req_valid,
    output logic                 ic_req_ready,
    input  logic [ADDR_BITS-1:0] ic_req_addr,
    output logic                 ic_resp_valid,
    input  logic                 dc_req_valid,
    output logic                 dc_req_ready,
    input  logic                 dc_req_rw,
    input  logic [ADDR_BITS-1:0] dc_req_addr,
    output logic                 dc_resp_valid,
    input  logic                 wdata_fire,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_rw,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [TAG_BITS-1:0]  mem_req_tag,
    input  logic                 mem_resp_valid,
    input  logic [TAG_BITS-1:0]  mem_resp_tag,
    output logic                 tag_err
);

    localparam int SEQ_BITS = TAG_BITS - 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int BW = $clog2(RD_BEATS + 1);
    localparam int WW = $clog2(WR_BEATS + 1);
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUT);
    localparam logic [BW-1:0] BEAT_LAST = BW'(RD_BEATS - 1);
    localparam logic [WW-1:0] WR_MAX    = WW'(WR_BEATS);

    typedef enum logic [1:0] {IDLE, ISSUE, WDATA} state_t;

    state_t                state, state_nxt;
    logic                  g_src, g_rw, last_grant;
    logic [ADDR_BITS-1:0]  g_addr;
    logic [TAG_BITS-1:0]   g_tag;
    logic [SEQ_BITS-1:0]   seq;
    logic [OW-1:0]         out_cnt;
    logic [BW-1:0]         beat_cnt;
    logic [WW-1:0]         wcnt, wcnt_nxt;
    logic                  ic_elig, dc_elig, pick_dc, grant, handshake;
    logic                  wcount_en, wr_done, resp_ok, rd_last, rd_issue;

    // Writes carry no response, so they bypass the outstanding-read limit.
    assign ic_elig   = ic_req_valid & (out_cnt < OUT_MAX);
    assign dc_elig   = dc_req_valid & (dc_req_rw | (out_cnt < OUT_MAX));
    assign pick_dc   = dc_elig & (~ic_elig | ~last_grant);
    assign grant     = (state == IDLE) & (ic_elig | dc_elig);
    assign handshake = (state == ISSUE) & mem_req_ready;

    assign wcount_en = (((state == ISSUE) & g_rw) | (state == WDATA)) & wdata_fire & (wcnt != WR_MAX);
    assign wcnt_nxt  = wcount_en ? wcnt + WW'(1) : wcnt;
    assign wr_done   = (wcnt_nxt == WR_MAX);

    assign resp_ok   = mem_resp_valid & (out_cnt != '0);
    assign rd_last   = resp_ok & (beat_cnt == BEAT_LAST);
    assign rd_issue  = handshake & ~g_rw;

    assign mem_req_valid = (state == ISSUE);
    assign mem_req_rw    = g_rw;
    assign mem_req_addr  = g_addr;
    assign mem_req_tag   = g_tag;
    assign ic_req_ready  = handshake & ~g_src;
    assign dc_req_ready  = handshake & g_src;
    assign ic_resp_valid = resp_ok & ~mem_resp_tag[TAG_BITS-1];
    assign dc_resp_valid = resp_ok & mem_resp_tag[TAG_BITS-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   if (mem_req_ready) state_nxt = (~g_rw | wr_done) ? IDLE : WDATA;
            WDATA:   if (wr_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            g_src      <= 1'b0;
            g_rw       <= 1'b0;
            g_addr     <= '0;
            g_tag      <= '0;
            last_grant <= 1'b1;
            seq        <= '0;
            wcnt       <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= (state_nxt == IDLE) ? '0 : wcnt_nxt;
            if (grant) begin
                g_src      <= pick_dc;
                g_rw       <= pick_dc & dc_req_rw;
                g_addr     <= pick_dc ? dc_req_addr : ic_req_addr;
                g_tag      <= {pick_dc, seq};
                last_grant <= pick_dc;
            end
            if (handshake) seq <= seq + SEQ_BITS'(1);
        end
    end

    // Beats of different reads never interleave, so one beat counter suffices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_cnt  <= '0;
            beat_cnt <= '0;
            tag_err  <= 1'b0;
        end else begin
            if (rd_issue & ~rd_last)      out_cnt <= out_cnt + OW'(1);
            else if (~rd_issue & rd_last) out_cnt <= out_cnt - OW'(1);
            if (resp_ok) beat_cnt <= rd_last ? '0 : beat_cnt + BW'(1);
            if (mem_resp_valid & (out_cnt == '0)) tag_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scenario bench for mem_rr_arbiter: expected grants and response owners are queued
// as stimulus is applied and compared when the arbiter issues or routes.
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [27:0] ic_req_addr;
    logic        dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
    logic [27:0] dc_req_addr;
    logic        wdata_fire;
    logic        mem_req_valid, mem_req_ready, mem_req_rw;
    logic [27:0] mem_req_addr;
    logic [4:0]  mem_req_tag;
    logic        mem_resp_valid;
    logic [4:0]  mem_resp_tag;
    logic        tag_err;

    typedef struct {logic rw; logic [27:0] addr; logic [4:0] tag;} req_t;
    req_t exp_q[$];
    bit   src_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mem_rr_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_resp_valid(dc_resp_valid),
        .wdata_fire(wdata_fire),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
        .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Returns the number of cycles until mem_req_valid is seen, or -1 on timeout.
    task automatic wait_req(input int budget, output int n);
        int k = 0;
        n = -1;
        while (k < budget) begin
            step();
            k++;
            if (mem_req_valid) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic do_reset();
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
        wdata_fire = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_tag = '0;
        exp_q.delete(); src_q.delete();
        reset_n = 0;
        step(); step();
        reset_n = 1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 0; #1;
        total_cnt++; if ({mem_req_valid, ic_req_ready, dc_req_ready, mem_req_rw, tag_err} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {mem_req_valid, ic_req_ready, dc_req_ready, mem_req_rw, tag_err}); else pass_cnt++;
        total_cnt++; if ({mem_req_addr, mem_req_tag} !== 33'h0)
            $display("FAIL reset_addr_tag got %0h want 0", {mem_req_addr, mem_req_tag}); else pass_cnt++;
        reset_n = 1;
        step();
    endtask

    task automatic test_ic_read();
        int n;
        req_t e;
        do_reset();
        ic_req_valid = 1; ic_req_addr = 28'h100;
        exp_q.push_back('{1'b0, 28'h100, 5'h00});
        wait_req(3, n);
        total_cnt++; if (n !== 1) $display("FAIL ic_latency got %0d want 1", n); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if ({mem_req_rw, mem_req_addr, mem_req_tag} !== {e.rw, e.addr, e.tag})
            $display("FAIL ic_req got %0h want %0h", {mem_req_rw, mem_req_addr, mem_req_tag}, {e.rw, e.addr, e.tag}); else pass_cnt++;
        total_cnt++; if (ic_req_ready !== 1'b0) $display("FAIL ic_ready_early got %b want 0", ic_req_ready); else pass_cnt++;
        mem_req_ready = 1; #1;
        total_cnt++; if ({ic_req_ready, dc_req_ready} !== 2'b10)
            $display("FAIL ic_ready got %b want 10", {ic_req_ready, dc_req_ready}); else pass_cnt++;
        step();
        total_cnt++; if ({mem_req_valid, ic_req_ready} !== 2'b00)
            $display("FAIL ic_ready_pulse got %b want 00", {mem_req_valid, ic_req_ready}); else pass_cnt++;
        ic_req_valid = 0; mem_req_ready = 0;
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1; mem_resp_tag = 5'h00; #1;
            total_cnt++; if ({ic_resp_valid, dc_resp_valid} !== 2'b10)
                $display("FAIL ic_beat%0d got %b want 10", b, {ic_resp_valid, dc_resp_valid}); else pass_cnt++;
            step();
        end
        mem_resp_valid = 0;
        total_cnt++; if (tag_err !== 1'b0) $display("FAIL ic_no_tag_err got %b want 0", tag_err); else pass_cnt++;
    endtask

    task automatic test_alternate();
        int n;
        int blocked;
        req_t e;
        bit s;
        do_reset();
        ic_req_valid = 1; ic_req_addr = 28'h100;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 28'h200;
        mem_req_ready = 1;
        exp_q.push_back('{1'b0, 28'h100, 5'h00});
        exp_q.push_back('{1'b0, 28'h200, 5'h11});
        exp_q.push_back('{1'b0, 28'h100, 5'h02});
        exp_q.push_back('{1'b0, 28'h200, 5'h13});
        for (int g = 0; g < 4; g++) begin
            wait_req(5, n);
            total_cnt++; if (n !== ((g == 0) ? 1 : 2)) $display("FAIL alt_gap%0d got %0d want %0d", g, n, (g == 0) ? 1 : 2); else pass_cnt++;
            e = exp_q.pop_front();
            total_cnt++; if ({mem_req_rw, mem_req_addr, mem_req_tag} !== {e.rw, e.addr, e.tag})
                $display("FAIL alt_req%0d got %0h want %0h", g, {mem_req_rw, mem_req_addr, mem_req_tag}, {e.rw, e.addr, e.tag}); else pass_cnt++;
            total_cnt++; if ({ic_req_ready, dc_req_ready} !== {~e.tag[4], e.tag[4]})
                $display("FAIL alt_ready%0d got %b want %b", g, {ic_req_ready, dc_req_ready}, {~e.tag[4], e.tag[4]}); else pass_cnt++;
            src_q.push_back(e.tag[4]);
        end
        step();
        ic_req_valid = 0; dc_req_valid = 0;
        blocked = 0;
        repeat (5) begin step(); if (mem_req_valid) blocked = 1; end
        ic_req_valid = 1;
        repeat (3) begin step(); if (mem_req_valid) blocked = 1; end
        total_cnt++; if (blocked !== 0) $display("FAIL alt_full got %0d want 0", blocked); else pass_cnt++;
        ic_req_valid = 0;
        for (int r = 0; r < 4; r++) begin
            s = src_q.pop_front();
            for (int b = 0; b < 4; b++) begin
                mem_resp_valid = 1; mem_resp_tag = {s, 4'(r)}; #1;
                total_cnt++; if ({ic_resp_valid, dc_resp_valid} !== {~s, s})
                    $display("FAIL alt_route r%0d b%0d got %b want %b", r, b, {ic_resp_valid, dc_resp_valid}, {~s, s}); else pass_cnt++;
                step();
            end
        end
        mem_resp_valid = 0;
        mem_req_ready = 0;
    endtask

    task automatic test_write();
        int n;
        int blocked;
        req_t e;
        do_reset();
        mem_req_ready = 1;
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h40;
        exp_q.push_back('{1'b1, 28'h40, 5'h10});
        wait_req(3, n);
        e = exp_q.pop_front();
        total_cnt++; if ({mem_req_rw, mem_req_addr, mem_req_tag} !== {e.rw, e.addr, e.tag})
            $display("FAIL wr_req got %0h want %0h", {mem_req_rw, mem_req_addr, mem_req_tag}, {e.rw, e.addr, e.tag}); else pass_cnt++;
        total_cnt++; if (dc_req_ready !== 1'b1) $display("FAIL wr_ready got %b want 1", dc_req_ready); else pass_cnt++;
        ic_req_valid = 1; ic_req_addr = 28'h80;
        exp_q.push_back('{1'b0, 28'h80, 5'h01});
        step();
        dc_req_valid = 0; dc_req_rw = 0;
        blocked = 0;
        repeat (6) begin if (mem_req_valid) blocked = 1; step(); end
        for (int i = 0; i < 4; i++) begin
            wdata_fire = 1;
            step();
            if (mem_req_valid) blocked = 1;
        end
        wdata_fire = 0;
        total_cnt++; if (blocked !== 0) $display("FAIL wr_block got %0d want 0", blocked); else pass_cnt++;
        wait_req(4, n);
        total_cnt++; if (n !== 1) $display("FAIL wr_after got %0d want 1", n); else pass_cnt++;
        e = exp_q.pop_front();
        total_cnt++; if ({mem_req_rw, mem_req_addr, mem_req_tag} !== {e.rw, e.addr, e.tag})
            $display("FAIL wr_next_req got %0h want %0h", {mem_req_rw, mem_req_addr, mem_req_tag}, {e.rw, e.addr, e.tag}); else pass_cnt++;
        step();
        ic_req_valid = 0; mem_req_ready = 0;
    endtask

    task automatic test_max_out();
        int n;
        int early;
        do_reset();
        mem_req_ready = 1;
        ic_req_valid = 1; ic_req_addr = 28'h300;
        for (int g = 0; g < 4; g++) exp_q.push_back('{1'b0, 28'h300, 5'(g)});
        exp_q.push_back('{1'b0, 28'h300, 5'h04});
        for (int g = 0; g < 4; g++) begin
            req_t e;
            wait_req(4, n);
            e = exp_q.pop_front();
            total_cnt++; if ((n < 0) || (mem_req_tag !== e.tag))
                $display("FAIL max_grant%0d got n=%0d tag %0h want tag %0h", g, n, mem_req_tag, e.tag); else pass_cnt++;
        end
        step();
        early = 0;
        repeat (6) begin step(); if (mem_req_valid) early = 1; end
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1; mem_resp_tag = 5'h00;
            step();
            if (mem_req_valid) early = 1;
        end
        mem_resp_valid = 0;
        total_cnt++; if (early !== 0) $display("FAIL max_block got %0d want 0", early); else pass_cnt++;
        wait_req(4, n);
        begin
            req_t e = exp_q.pop_front();
            total_cnt++; if ((n !== 1) || (mem_req_tag !== e.tag))
                $display("FAIL max_fifth got n=%0d tag %0h want n=1 tag %0h", n, mem_req_tag, e.tag); else pass_cnt++;
        end
        step();
        ic_req_valid = 0; mem_req_ready = 0;
    endtask

    task automatic test_tag_err();
        do_reset();
        mem_resp_valid = 1; mem_resp_tag = 5'h10; #1;
        total_cnt++; if ({ic_resp_valid, dc_resp_valid, tag_err} !== 3'b000)
            $display("FAIL err_fwd got %b want 000", {ic_resp_valid, dc_resp_valid, tag_err}); else pass_cnt++;
        step();
        mem_resp_valid = 0;
        total_cnt++; if (tag_err !== 1'b1) $display("FAIL err_set got %b want 1", tag_err); else pass_cnt++;
        repeat (5) step();
        total_cnt++; if (tag_err !== 1'b1) $display("FAIL err_sticky got %b want 1", tag_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        mem_req_ready = 1;
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h40;
        wait_req(3, n);
        step();
        dc_req_valid = 0; dc_req_rw = 0;
        wdata_fire = 1;
        step(); step();
        wdata_fire = 0;
        ic_req_valid = 1; ic_req_addr = 28'h500;
        dc_req_valid = 1; dc_req_addr = 28'h600;
        reset_n = 0; #1;
        total_cnt++; if ({mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready, tag_err} !== 5'b0)
            $display("FAIL rst_mid_ctrl got %b want 00000", {mem_req_valid, mem_req_rw, ic_req_ready, dc_req_ready, tag_err}); else pass_cnt++;
        total_cnt++; if ({mem_req_addr, mem_req_tag} !== 33'h0)
            $display("FAIL rst_mid_addr got %0h want 0", {mem_req_addr, mem_req_tag}); else pass_cnt++;
        step();
        total_cnt++; if (mem_req_valid !== 1'b0) $display("FAIL rst_hold got %b want 0", mem_req_valid); else pass_cnt++;
        reset_n = 1;
        wait_req(3, n);
        total_cnt++; if ((n !== 1) || ({mem_req_addr, mem_req_tag} !== {28'h500, 5'h00}) || (ic_req_ready !== 1'b1))
            $display("FAIL rst_first_grant got n=%0d %0h rdy %b want n=1 %0h rdy 1", n, {mem_req_addr, mem_req_tag}, ic_req_ready, {28'h500, 5'h00}); else pass_cnt++;
        step();
        ic_req_valid = 0; dc_req_valid = 0; mem_req_ready = 0;
    endtask

    initial begin
        test_reset();
        test_ic_read();
        test_alternate();
        test_write();
        test_max_out();
        test_tag_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
